// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the CPU clock-enable controller.
// Holds the FSM state encoding and the default counter widths.
package clk_ctrl_pkg;

   localparam int DIV_SEL_W = 5;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      HALT = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_e;

endpackage

// File: rtl/tick_gen.sv
// Divide counter: raises tick once every 2^(div_q+1) cycles, with the
// period capped at 2^CNT_W. While hold_i is high the counter sits at zero.
module tick_gen
   import clk_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold_i,
   input  logic [DIV_SEL_W-1:0] div_sel_i,
   output logic                 tick_o
);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DIV_SEL_W-1:0] div_q, div_d;
   logic [CNT_W-1:0]     mask;

   // Build the terminal count bit by bit so large divisors saturate to all ones.
   for (genvar gi = 0; gi < CNT_W; gi++) begin : g_mask
      assign mask[gi] = ({{(32-DIV_SEL_W){1'b0}}, div_q} >= 32'(gi));
   end

   assign tick_o = !hold_i && (cnt_q == mask);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      div_d = div_q;
      if (hold_i || tick_o) begin
         cnt_d = '0;
      end
      // Only reload the divisor at a period boundary so a running period is never cut short.
      if (hold_i || tick_o) begin
         div_d = div_sel_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         div_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/clk_en_ctrl.sv
// CPU clock-enable controller: run / halt / single-step FSM on top of
// tick_gen, producing registered enable and step-acknowledge pulses.
module clk_en_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_SEL_W-1:0] div_sel,
   input  logic                 run_req,
   input  logic                 halt_req,
   input  logic                 step_req,
   output logic                 cpu_en,
   output logic                 step_ack,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     en_cnt
);

   state_e           state_q, state_d;
   logic             cpu_en_q, cpu_en_d;
   logic             step_ack_q, step_ack_d;
   logic [CNT_W-1:0] en_cnt_q, en_cnt_d;
   logic             tick;
   logic             hold;

   assign hold = (state_q == HALT);

   tick_gen #(
      .CNT_W(CNT_W)
   ) u_tick_gen (
      .clk      (clk),
      .rst      (rst),
      .hold_i   (hold),
      .div_sel_i(div_sel),
      .tick_o   (tick)
   );

   // halt_req always wins; a halt arriving on a tick cycle also drops that pulse.
   always_comb begin
      state_d    = state_q;
      cpu_en_d   = 1'b0;
      step_ack_d = 1'b0;
      case (state_q)
         HALT: begin
            if (halt_req) begin
               state_d = HALT;
            end else if (run_req) begin
               state_d = RUN;
            end else if (step_req) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (halt_req) begin
               state_d = HALT;
            end else begin
               cpu_en_d = tick;
            end
         end
         STEP: begin
            if (halt_req) begin
               state_d = HALT;
            end else if (run_req) begin
               state_d  = RUN;
               cpu_en_d = tick;
            end else if (tick) begin
               cpu_en_d   = 1'b1;
               step_ack_d = 1'b1;
               state_d    = HALT;
            end
         end
         default: begin
            state_d = HALT;
         end
      endcase
      en_cnt_d = en_cnt_q + CNT_W'(cpu_en_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HALT;
         cpu_en_q   <= 1'b0;
         step_ack_q <= 1'b0;
         en_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         cpu_en_q   <= cpu_en_d;
         step_ack_q <= step_ack_d;
         en_cnt_q   <= en_cnt_d;
      end
   end

   assign cpu_en   = cpu_en_q;
   assign step_ack = step_ack_q;
   assign state    = state_q;
   assign en_cnt   = en_cnt_q;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Self-checking bench for clk_en_ctrl (CNT_W=4 build): expected pulse cycles
// are queued when requests are driven and popped as cpu_en/step_ack appear.
module tb_clk_en_ctrl;
   import clk_ctrl_pkg::*;

   localparam int CW = 4;
   localparam logic [2:0] R_HALT = 3'b100;
   localparam logic [2:0] R_RUN  = 3'b010;
   localparam logic [2:0] R_STEP = 3'b001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    div_sel = '0;
   logic          run_req = 1'b0;
   logic          halt_req = 1'b0;
   logic          step_req = 1'b0;
   logic          cpu_en;
   logic          step_ack;
   logic [1:0]    state;
   logic [CW-1:0] en_cnt;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int en_q[$];
   int ack_q[$];
   logic prev_en = 1'b0;
   int n;

   clk_en_ctrl #(.CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .div_sel (div_sel),
      .run_req (run_req),
      .halt_req(halt_req),
      .step_req(step_req),
      .cpu_en  (cpu_en),
      .step_ack(step_ack),
      .state   (state),
      .en_cnt  (en_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end else begin
         $display("[TB] ok %s = %0d (cycle %0d)", tag, obs, cyc);
      end
   endtask

   // Scoreboard monitor: every enable / ack must match the next queued cycle.
   always @(negedge clk) begin
      if (cpu_en === 1'b1) begin
         check_eq("no_b2b_en", 64'(prev_en), 64'd0);
         if (en_q.size() == 0) check_eq("unexp_en", 64'(cpu_en), 64'd0);
         else check_eq("en_cycle", 64'(cyc), 64'(en_q.pop_front()));
      end
      if (step_ack === 1'b1) begin
         check_eq("ack_has_en", 64'(cpu_en), 64'd1);
         if (ack_q.size() == 0) check_eq("unexp_ack", 64'(step_ack), 64'd0);
         else check_eq("ack_cycle", 64'(cyc), 64'(ack_q.pop_front()));
      end
      prev_en <= (cpu_en === 1'b1);
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic req_at(input int c, input logic [2:0] r);
      wait_to(c);
      {halt_req, run_req, step_req} = r;
      @(negedge clk);
      {halt_req, run_req, step_req} = 3'b000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      {halt_req, run_req, step_req} = 3'b000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_sb_empty(input string tag);
      check_eq({tag, "_en_q_empty"}, 64'(en_q.size()), 64'd0);
      check_eq({tag, "_ack_q_empty"}, 64'(ack_q.size()), 64'd0);
      en_q.delete();
      ack_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check_eq("rst_state", 64'(state), 64'(HALT));
      check_eq("rst_cpu_en", 64'(cpu_en), 64'd0);
      check_eq("rst_step_ack", 64'(step_ack), 64'd0);
      check_eq("rst_en_cnt", 64'(en_cnt), 64'd0);

      // div 0 run: pulses at N+3, N+5, ...
      do_reset();
      div_sel = 5'd0;
      n = cyc + 2;
      for (int i = 0; i < 5; i++) en_q.push_back(n + 3 + 2 * i);
      req_at(n, R_RUN);
      check_eq("run_state", 64'(state), 64'(RUN));
      req_at(n + 11, R_HALT);
      wait_to(n + 13);
      check_eq("run0_halted", 64'(state), 64'(HALT));
      check_eq("run0_en_cnt", 64'(en_cnt), 64'd5);
      check_sb_empty("run0");

      // div 2 then switch to div 0 mid-period: the 8-cycle period completes first
      do_reset();
      div_sel = 5'd2;
      n = cyc + 2;
      en_q.push_back(n + 9);
      en_q.push_back(n + 17);
      en_q.push_back(n + 25);
      en_q.push_back(n + 27);
      en_q.push_back(n + 29);
      req_at(n, R_RUN);
      wait_to(n + 18);
      div_sel = 5'd0;
      req_at(n + 29, R_HALT);
      wait_to(n + 31);
      check_eq("div_chg_en_cnt", 64'(en_cnt), 64'd5);
      check_sb_empty("div_chg");

      // single step with div 1: one pulse + ack at S+5
      do_reset();
      div_sel = 5'd1;
      n = cyc + 2;
      en_q.push_back(n + 5);
      ack_q.push_back(n + 5);
      req_at(n, R_STEP);
      wait_to(n + 2);
      check_eq("step_state", 64'(state), 64'(STEP));
      wait_to(n + 6);
      check_eq("step_done_state", 64'(state), 64'(HALT));
      check_eq("step_en_cnt", 64'(en_cnt), 64'd1);
      wait_to(n + 30);
      check_eq("step_en_cnt_late", 64'(en_cnt), 64'd1);
      check_sb_empty("step");

      // run+halt together in HALT stays halted; step in RUN adds nothing
      do_reset();
      div_sel = 5'd0;
      n = cyc + 2;
      req_at(n, R_RUN | R_HALT);
      check_eq("prio_state", 64'(state), 64'(HALT));
      wait_to(n + 101);
      check_eq("prio_state_100", 64'(state), 64'(HALT));
      check_eq("prio_en_cnt", 64'(en_cnt), 64'd0);
      n = cyc + 2;
      en_q.push_back(n + 3);
      en_q.push_back(n + 5);
      en_q.push_back(n + 7);
      req_at(n, R_RUN);
      req_at(n + 4, R_STEP);
      check_eq("step_in_run_state", 64'(state), 64'(RUN));
      req_at(n + 7, R_HALT);
      wait_to(n + 9);
      check_eq("step_in_run_en_cnt", 64'(en_cnt), 64'd3);
      check_sb_empty("step_in_run");

      // reset in RUN one cycle before a tick
      do_reset();
      div_sel = 5'd1;
      n = cyc + 2;
      en_q.push_back(n + 5);
      req_at(n, R_RUN);
      wait_to(n + 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_run_cpu_en", 64'(cpu_en), 64'd0);
      check_eq("rst_run_ack", 64'(step_ack), 64'd0);
      check_eq("rst_run_state", 64'(state), 64'(HALT));
      check_eq("rst_run_en_cnt", 64'(en_cnt), 64'd0);
      wait_to(n + 20);
      check_sb_empty("rst_run");

      // reset on the tick cycle of a step suppresses the pending pulse
      do_reset();
      div_sel = 5'd0;
      n = cyc + 2;
      req_at(n, R_STEP);
      wait_to(n + 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_step_cpu_en", 64'(cpu_en), 64'd0);
      check_eq("rst_step_ack", 64'(step_ack), 64'd0);
      check_eq("rst_step_state", 64'(state), 64'(HALT));
      wait_to(n + 10);
      check_sb_empty("rst_step");

      // halt aborts a step
      do_reset();
      div_sel = 5'd1;
      n = cyc + 2;
      req_at(n, R_STEP);
      req_at(n + 2, R_HALT);
      wait_to(n + 4);
      check_eq("abort_state", 64'(state), 64'(HALT));
      wait_to(n + 12);
      check_eq("abort_en_cnt", 64'(en_cnt), 64'd0);
      check_sb_empty("abort");

      // en_cnt wraps 15 -> 0
      do_reset();
      div_sel = 5'd0;
      n = cyc + 2;
      for (int i = 0; i < 16; i++) en_q.push_back(n + 3 + 2 * i);
      req_at(n, R_RUN);
      wait_to(n + 32);
      check_eq("wrap_en_cnt_15", 64'(en_cnt), 64'd15);
      req_at(n + 33, R_HALT);
      check_eq("wrap_en_cnt_0", 64'(en_cnt), 64'd0);
      check_eq("wrap_state", 64'(state), 64'(HALT));
      check_sb_empty("wrap");

      // div_sel=31 saturates to a full CNT_W period (16 cycles)
      do_reset();
      div_sel = 5'd31;
      n = cyc + 2;
      en_q.push_back(n + 17);
      en_q.push_back(n + 33);
      req_at(n, R_RUN);
      req_at(n + 33, R_HALT);
      wait_to(n + 35);
      check_eq("div31_en_cnt", 64'(en_cnt), 64'd2);
      check_sb_empty("div31");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
